// File: rtl/axis_sample_generator_if.sv
// ---------------------------------------------------------------------------
// axis_sample_generator_if
//   AXI4-Stream bundle between the sample generator (master) and its sink
//   (rotator input or loopback checker, slave).
//   Signals:
//     tvalid  master->slave  beat valid
//     tready  slave->master  sink ready
//     tlast   master->slave  last beat of packet
//     tdata   master->slave  sample data, DATA_W bits
//     tuser   master->slave  start of frame (only with SAMPGEN_TUSER_SOF_EN)
// ---------------------------------------------------------------------------
interface axis_sample_generator_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
`ifdef SAMPGEN_TUSER_SOF_EN
  logic              tuser;
`endif

  modport master (
    output tvalid,
    output tlast,
    output tdata,
`ifdef SAMPGEN_TUSER_SOF_EN
    output tuser,
`endif
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
`ifdef SAMPGEN_TUSER_SOF_EN
    input  tuser,
`endif
    output tready
  );
endinterface

// File: rtl/axis_sample_generator.sv
// ---------------------------------------------------------------------------
// axis_sample_generator
//   AXI4-Stream master producing test-sample packets for the image-rotator
//   datapath. Packet length is chosen at runtime, four data patterns are
//   available, generation is held off for a fixed number of cycles after
//   reset release, and a started packet always runs to its tlast beat.
//
//   Optional feature macro: SAMPGEN_TUSER_SOF_EN
//     defined   -> tuser marks the first beat of packet 0 of every frame of
//                  C_PKTS_PER_FRAME packets
//     undefined -> no tuser, no packet counter
//
//   Ports:
//     Clk     clock, rising edge
//     ResetN  asynchronous active-low reset
//     En      generation enable (level)
//     PktLen  beats per packet, sampled at packet start (0 -> 1, clipped)
//     Mode    0 per-packet ramp, 1 free-running ramp, 2 walking one,
//             3 constant Seed
//     Seed    ramp start / constant value
//     M_AXIS  stream master (tvalid/tready/tlast/tdata[/tuser])
//     Busy    high from first beat presented until tlast accepted
// ---------------------------------------------------------------------------
module axis_sample_generator #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_START_COUNT      = 32,
  parameter int C_MAX_PKT_LEN        = 1024,
  parameter int C_PKTS_PER_FRAME     = 480,
  localparam int LW = $clog2(C_MAX_PKT_LEN) + 1
) (
  input  logic                            Clk,
  input  logic                            ResetN,
  input  logic                            En,
  input  logic [LW-1:0]                   PktLen,
  input  logic [1:0]                      Mode,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] Seed,
  axis_sample_generator_if.master         M_AXIS,
  output logic                            Busy
);
  localparam int W   = C_M_AXIS_TDATA_WIDTH;
  localparam int SCW = $clog2(C_M_START_COUNT + 1) + 1;

  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_FREE = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  // -------------------------------------------------------------------------
  // Post-reset start delay: counts up once, then parks with start_ok_q set.
  // -------------------------------------------------------------------------
  logic [SCW-1:0] start_cnt_q;
  logic           start_ok_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      start_cnt_q <= '0;
      start_ok_q  <= 1'b0;
    end else if (!start_ok_q) begin
      start_cnt_q <= start_cnt_q + SCW'(1);
      if (int'(start_cnt_q) + 1 >= C_M_START_COUNT) start_ok_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Packet FSM and registered stream outputs
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic [W-1:0]    tdata_q, tdata_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [LW-1:0]   len_q, len_d;
  logic [1:0]      mode_q, mode_d;
  logic [LW-1:0]   len_new;
  logic [W-1:0]    first_data;
  logic [W-1:0]    next_data;
  logic            start_pkt;

  // Effective length of a packet starting now.
  always_comb begin
    if (PktLen == '0)                       len_new = LW'(1);
    else if (PktLen > LW'(C_MAX_PKT_LEN))   len_new = LW'(C_MAX_PKT_LEN);
    else                                    len_new = PktLen;
  end

  // First beat of a packet starting now. The free-running ramp only reseeds
  // when starting from IDLE; back-to-back it continues from the last beat.
  always_comb begin
    case (Mode)
      MODE_FREE: first_data = (state_q == ST_SEND) ? tdata_q + W'(1) : Seed;
      MODE_WALK: first_data = W'(1);
      default:   first_data = Seed;
    endcase
  end

  // Following beat within the current packet.
  always_comb begin
    case (mode_q)
      MODE_RAMP, MODE_FREE: next_data = tdata_q + W'(1);
      MODE_WALK:            next_data = {tdata_q[W-2:0], tdata_q[W-1]};
      default:              next_data = tdata_q;
    endcase
  end

`ifdef SAMPGEN_TUSER_SOF_EN
  localparam int PW = (C_PKTS_PER_FRAME > 1) ? $clog2(C_PKTS_PER_FRAME) : 1;
  logic [PW-1:0] pkt_q, pkt_d;
  logic          tuser_q, tuser_d;
`else
  // The frame size only matters when the SOF marker is built in.
  if (C_PKTS_PER_FRAME < 1) begin : g_no_frames
  end
`endif

  always_comb begin
    state_d   = state_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    beat_d    = beat_q;
    len_d     = len_q;
    mode_d    = mode_q;
    start_pkt = 1'b0;
`ifdef SAMPGEN_TUSER_SOF_EN
    pkt_d     = pkt_q;
    tuser_d   = tuser_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok_q && En) begin
          state_d   = ST_SEND;
          start_pkt = 1'b1;
        end
      end
      ST_SEND: begin
        if (tvalid_q && M_AXIS.tready) begin
          if (tlast_q) begin
`ifdef SAMPGEN_TUSER_SOF_EN
            pkt_d = (pkt_q == PW'(C_PKTS_PER_FRAME - 1)) ? '0 : pkt_q + PW'(1);
`endif
            if (En) begin
              start_pkt = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
`ifdef SAMPGEN_TUSER_SOF_EN
              pkt_d    = '0;
              tuser_d  = 1'b0;
`endif
            end
          end else begin
            beat_d  = beat_q + LW'(1);
            tlast_d = ((beat_q + LW'(1)) == (len_q - LW'(1)));
            tdata_d = next_data;
`ifdef SAMPGEN_TUSER_SOF_EN
            tuser_d = 1'b0;
`endif
          end
        end
      end
    endcase

    if (start_pkt) begin
      tvalid_d = 1'b1;
      len_d    = len_new;
      mode_d   = Mode;
      beat_d   = '0;
      tdata_d  = first_data;
      tlast_d  = (len_new == LW'(1));
`ifdef SAMPGEN_TUSER_SOF_EN
      tuser_d  = (pkt_d == '0);
`endif
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      mode_q   <= '0;
`ifdef SAMPGEN_TUSER_SOF_EN
      pkt_q    <= '0;
      tuser_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
`ifdef SAMPGEN_TUSER_SOF_EN
      pkt_q    <= pkt_d;
      tuser_q  <= tuser_d;
`endif
    end
  end

  assign M_AXIS.tvalid = tvalid_q;
  assign M_AXIS.tlast  = tlast_q;
  assign M_AXIS.tdata  = tdata_q;
`ifdef SAMPGEN_TUSER_SOF_EN
  assign M_AXIS.tuser  = tuser_q;
`endif
  assign Busy = (state_q == ST_SEND);

endmodule
